temp_history_buffer: RTL and testbench

- Sample history stage directly downstream of the temperature-monitor slave. The slave's divided sample strobe and raw temperature feed it. Its window statistics and addressed readback feed the slave's OUT_MAX, OUT_MIN, OUT_AVG and OUT_ADDR commands.
- Circular store of the last DEPTH samples. After each new sample, a sequential scan-plus-divide engine recomputes max, min and floor-average over the valid window.

---
 rtl/temp_history_if.sv | 45 ++++
 rtl/temp_history_buffer.sv | 173 +++++++++++++++++
 tb/tb_temp_history_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/temp_history_if.sv
// Sample/readback/statistics bundle for temp_history_buffer.
// Defining TEMP_HISTORY_OVERRUN_EN adds the sticky overrun flag.
interface temp_history_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          sample_en;
  logic [DW-1:0] sample_in;
  logic          clear;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] max_out;
  logic [DW-1:0] min_out;
  logic [DW-1:0] avg_out;
  logic [AW:0]   count;
  logic          full;
  logic          stats_valid;
`ifdef TEMP_HISTORY_OVERRUN_EN
  logic          overrun;

  modport master (
    output sample_en, sample_in, clear, rd_addr,
    input  rd_data, max_out, min_out, avg_out,
    input  count, full, stats_valid, overrun
  );
  modport slave (
    input  sample_en, sample_in, clear, rd_addr,
    output rd_data, max_out, min_out, avg_out,
    output count, full, stats_valid, overrun
  );
`else
  modport master (
    output sample_en, sample_in, clear, rd_addr,
    input  rd_data, max_out, min_out, avg_out,
    input  count, full, stats_valid
  );
  modport slave (
    input  sample_en, sample_in, clear, rd_addr,
    output rd_data, max_out, min_out, avg_out,
    output count, full, stats_valid
  );
`endif
endinterface

// File: rtl/temp_history_buffer.sv
// Circular sample history with sequential max/min/floor-average engine.
// Optional sticky overrun flag: define TEMP_HISTORY_OVERRUN_EN.
module temp_history_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  temp_history_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DW + AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          pending;
  logic          stats_valid;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] max_out;
  logic [DW-1:0] min_out;
  logic [DW-1:0] avg_out;

  logic [AW:0]   n_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   idx;
  logic [DW-1:0] scan_q;
  logic          scan_v;
  logic [DW-1:0] max_acc;
  logic [DW-1:0] min_acc;
  logic [SW-1:0] sum;
  logic [AW-1:0] rem;
  logic [$clog2(SW)-1:0] div_cnt;

  logic          wr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] scan_idx;
  logic [AW:0]   rem_sh;
  logic          ge;
  logic [AW-1:0] rem_nx;

  assign wr       = bus.sample_en && !bus.clear;
  assign rd_idx   = wr_ptr - AW'(1) - bus.rd_addr;
  assign scan_idx = ptr_q + idx[AW-1:0];

  // Restoring-divide step: sum doubles as dividend and quotient shifter.
  assign rem_sh = {rem, sum[SW-1]};
  assign ge     = rem_sh >= n_q;
  assign rem_nx = ge ? AW'(rem_sh - n_q) : rem_sh[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.sample_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      count       <= '0;
      pending     <= 1'b0;
      stats_valid <= 1'b1;
      rd_data     <= '0;
      max_out     <= '0;
      min_out     <= '0;
      avg_out     <= '0;
      n_q         <= '0;
      ptr_q       <= '0;
      idx         <= '0;
      scan_q      <= '0;
      scan_v      <= 1'b0;
      max_acc     <= '0;
      min_acc     <= '0;
      sum         <= '0;
      rem         <= '0;
      div_cnt     <= '0;
    end else if (bus.clear) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      count       <= '0;
      pending     <= 1'b0;
      stats_valid <= 1'b1;
      rd_data     <= '0;
      max_out     <= '0;
      min_out     <= '0;
      avg_out     <= '0;
    end else begin
      if ({1'b0, bus.rd_addr} < count) rd_data <= mem[rd_idx];
      else rd_data <= '0;

      unique case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            n_q     <= count;
            ptr_q   <= wr_ptr - count[AW-1:0];
            idx     <= '0;
            scan_v  <= 1'b0;
            max_acc <= '0;
            min_acc <= '1;
            sum     <= '0;
            rem     <= '0;
            div_cnt <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          // Registered read: accumulation trails the fetch by one cycle.
          scan_v <= idx != n_q;
          if (idx != n_q) begin
            scan_q <= mem[scan_idx];
            idx    <= idx + 1'b1;
          end else begin
            state <= DIV;
          end
          if (scan_v) begin
            if (scan_q > max_acc) max_acc <= scan_q;
            if (scan_q < min_acc) min_acc <= scan_q;
            sum <= sum + SW'(scan_q);
          end
        end
        DIV: begin
          rem     <= rem_nx;
          sum     <= {sum[SW-2:0], ge};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == ($clog2(SW))'(SW - 1)) state <= DONE;
        end
        DONE: begin
          max_out <= max_acc;
          min_out <= min_acc;
          avg_out <= sum[DW-1:0];
          if (!pending) stats_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new sample always overrides the FSM's pending/valid updates.
      if (wr) begin
        wr_ptr      <= wr_ptr + 1'b1;
        pending     <= 1'b1;
        stats_valid <= 1'b0;
        if (count != (AW+1)'(DEPTH)) count <= count + 1'b1;
      end
    end
  end

`ifdef TEMP_HISTORY_OVERRUN_EN
  logic overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (bus.clear) overrun <= 1'b0;
    else if (bus.sample_en && pending) overrun <= 1'b1;
  end

  assign bus.overrun = overrun;
`endif

  assign bus.rd_data     = rd_data;
  assign bus.max_out     = max_out;
  assign bus.min_out     = min_out;
  assign bus.avg_out     = avg_out;
  assign bus.count       = count;
  assign bus.full        = count == (AW+1)'(DEPTH);
  assign bus.stats_valid = stats_valid;
endmodule

// File: tb/tb_temp_history_buffer.sv
// Randomized bench for temp_history_buffer against a queue-based window model.
// Overrun checks apply when TEMP_HISTORY_OVERRUN_EN is defined.
module tb_temp_history_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LAT   = DW + AW + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  temp_history_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  temp_history_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int win[$];
  bit ovr_m = 1'b0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int m_max();
    int r = 0;
    foreach (win[i]) if (win[i] > r) r = win[i];
    return r;
  endfunction

  function automatic int m_min();
    int r;
    if (win.size() == 0) return 0;
    r = win[0];
    foreach (win[i]) if (win[i] < r) r = win[i];
    return r;
  endfunction

  function automatic int m_avg();
    int s = 0;
    if (win.size() == 0) return 0;
    foreach (win[i]) s += win[i];
    return s / win.size();
  endfunction

  function automatic void m_push(int v);
    win.push_back(v);
    if (win.size() > DEPTH) void'(win.pop_front());
  endfunction

  task automatic put(int v);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.sample_in = DW'(v);
    @(negedge clk);
    bus.sample_en = 1'b0;
    m_push(v);
  endtask

  task automatic burst(int n);
    int v;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      v = $urandom_range(0, 255);
      bus.sample_en = 1'b1;
      bus.sample_in = DW'(v);
      m_push(v);
      @(negedge clk);
    end
    bus.sample_en = 1'b0;
    if (n > 1) ovr_m = 1'b1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    win.delete();
    ovr_m = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.stats_valid && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!bus.stats_valid) chk("timeout", 0, 1);
  endtask

  task automatic check_stats(string tag);
    chk({tag, ".max"}, bus.max_out, m_max());
    chk({tag, ".min"}, bus.min_out, m_min());
    chk({tag, ".avg"}, bus.avg_out, m_avg());
    chk({tag, ".count"}, bus.count, win.size());
    chk({tag, ".full"}, bus.full, win.size() == DEPTH);
`ifdef TEMP_HISTORY_OVERRUN_EN
    chk({tag, ".overrun"}, bus.overrun, ovr_m);
`endif
  endtask

  task automatic check_rd(int a);
    int e;
    @(negedge clk);
    bus.rd_addr = AW'(a);
    @(negedge clk);
    e = (a < win.size()) ? win[win.size() - 1 - a] : 0;
    chk($sformatf("rd[%0d]", a), bus.rd_data, e);
  endtask

  task automatic put_check(int v, string tag);
    int cyc;
    put(v);
    wait_valid(cyc);
    chk({tag, ".lat"}, cyc, win.size() + LAT);
    check_stats(tag);
  endtask

  initial begin
    int cyc;
    int r;
    bus.sample_en = 1'b0;
    bus.sample_in = '0;
    bus.clear     = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(negedge clk);
    chk("rst.count", bus.count, 0);
    chk("rst.full", bus.full, 0);
    chk("rst.max", bus.max_out, 0);
    chk("rst.min", bus.min_out, 0);
    chk("rst.avg", bus.avg_out, 0);
    chk("rst.rd", bus.rd_data, 0);
    chk("rst.sv", bus.stats_valid, 1);
    reset = 1'b0;

    put_check(10, "s10");
    put_check(20, "s20");
    put_check(30, "s30");
    check_rd(0);
    check_rd(2);
    check_rd(3);

    put_check(40, "s40");
    put_check(50, "wrap");
    check_rd(3);

    do_clear();
    put_check(1, "f1");
    put_check(2, "floor");
    do_clear();
    put_check(255, "h0");
    put_check(255, "h1");
    put_check(255, "h2");
    put_check(254, "h3");

    do_clear();
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.sample_in = 8'd5;
    @(negedge clk);
    bus.sample_in = 8'd9;
    @(negedge clk);
    bus.sample_in = 8'd7;
    @(negedge clk);
    bus.sample_en = 1'b0;
    m_push(5);
    m_push(9);
    m_push(7);
    ovr_m = 1'b1;
    chk("b2b.sv_low", bus.stats_valid, 0);
    wait_valid(cyc);
    check_stats("b2b");

    put(3);
    put(4);
    repeat (2) @(negedge clk);
    bus.clear     = 1'b1;
    bus.sample_en = 1'b1;
    bus.sample_in = 8'd99;
    @(negedge clk);
    bus.clear     = 1'b0;
    bus.sample_en = 1'b0;
    win.delete();
    ovr_m = 1'b0;
    chk("clr.sv", bus.stats_valid, 1);
    check_stats("clr");
    put_check(7, "post_clr");

    put(100);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    win.delete();
    ovr_m = 1'b0;
    chk("mid_rst.sv", bus.stats_valid, 1);
    check_stats("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    check_rd(0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_clear();
        check_stats("rnd_clr");
      end else if (r == 1) begin
        burst($urandom_range(2, 4));
        wait_valid(cyc);
        check_stats("rnd_burst");
      end else begin
        put_check($urandom_range(0, 255), "rnd");
      end
      check_rd($urandom_range(0, DEPTH - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
